// File: rtl/axis_sa_pkg.sv
// axis_sa shared types and width helpers.
// Keeps the systolic array and its downstream blocks agreeing on word width.
package axis_sa_pkg;

  localparam int SA_WX = 8;
  localparam int SA_WK = 8;
  localparam int SA_K  = 65536;

  function automatic int calc_wy(
    input int wx,
    input int wk,
    input int k
  );
    return wx + wk + $clog2(k);
  endfunction

  localparam int SA_WY = calc_wy(SA_WX, SA_WK, SA_K);

  typedef logic [SA_WY-1:0] sa_word_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_BUSY  = 1'b1
  } ds_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_y_downsizer.sv
// Splits each R-word AXIS beat from axis_sa into R/P beats of P words.
// Word 0 goes first; keep is sliced as-is, last rides the final sub-beat.
module axis_y_downsizer
  import axis_sa_pkg::*;
#(
  parameter int R  = 4,
  parameter int P  = 1,
  parameter int WY = SA_WY
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [R*WY-1:0] s_data,
  input  logic [R-1:0]    s_keep,
  input  logic            s_last,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [P*WY-1:0] m_data,
  output logic [P-1:0]    m_keep,
  output logic            m_last
);

  localparam int N  = R / P;
  localparam int IW = idx_w(N);
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  if ((R % P) != 0) begin : g_bad_p
    $error("axis_y_downsizer: P must divide R");
  end

  ds_state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          last_q, last_d;

  logic [N-1:0][P*WY-1:0] data_q;
  logic [N-1:0][P-1:0]    keep_q;

  logic acc;
  logic out;
  logic at_end;
  logic load;

  assign at_end  = (idx_q == IDX_LAST);
  assign m_valid = (state_q == ST_BUSY);
  assign out     = m_valid && m_ready;

  // Reload on the final sub-beat so back-to-back beats leave no bubble.
  assign s_ready = !rst &&
                   ((state_q == ST_EMPTY) ||
                    (m_ready && at_end));
  assign acc     = s_valid && s_ready;

  assign m_data = data_q[idx_q];
  assign m_keep = keep_q[idx_q];
  assign m_last = last_q && at_end;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    load    = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (out) begin
          if (!at_end) begin
            idx_d = idx_q + IW'(1);
          end else begin
            idx_d = '0;
            if (acc) begin
              load = 1'b1;
            end else begin
              state_d = ST_EMPTY;
            end
          end
        end
      end
      default: begin
        state_d = ST_EMPTY;
        idx_d   = '0;
      end
    endcase
    if (load) begin
      last_d = s_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      data_q <= s_data;
      keep_q <= s_keep;
    end
  end

endmodule

// File: tb/tb_axis_y_downsizer.sv
// Scoreboard bench for axis_y_downsizer: R=4/P=2 directed cases
// plus an R=8/P=2 instance under random valid/ready.
module tb_axis_y_downsizer;

  localparam int WY = 8;
  localparam int RA = 4;
  localparam int RB = 8;
  localparam int P  = 2;
  localparam int NB = RB / P;

  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  k;
    logic        l;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              s_valid, s_ready, s_last;
  logic [RA*WY-1:0]  s_data;
  logic [RA-1:0]     s_keep;
  logic              m_valid, m_ready, m_last;
  logic [P*WY-1:0]   m_data;
  logic [P-1:0]      m_keep;

  logic              b_s_valid, b_s_ready, b_s_last;
  logic [RB*WY-1:0]  b_s_data;
  logic [RB-1:0]     b_s_keep;
  logic              b_m_valid, b_m_last;
  logic              b_m_ready = 1'b1;
  logic [P*WY-1:0]   b_m_data;
  logic [P-1:0]      b_m_keep;

  axis_y_downsizer #(.R(RA), .P(P), .WY(WY)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_keep(s_keep), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_keep(m_keep), .m_last(m_last)
  );

  axis_y_downsizer #(.R(RB), .P(P), .WY(WY)) dut_b (
    .clk(clk), .rst(rst),
    .s_valid(b_s_valid), .s_ready(b_s_ready),
    .s_data(b_s_data), .s_keep(b_s_keep), .s_last(b_s_last),
    .m_valid(b_m_valid), .m_ready(b_m_ready),
    .m_data(b_m_data), .m_keep(b_m_keep), .m_last(b_m_last)
  );

  int checks = 0;
  int errors = 0;
  exp_t qa[$];
  exp_t qb[$];
  int a_cyc[$];
  int cyc = 0;
  int b_outs = 0;
  int b_mlast = 0;
  int b_slast = 0;
  bit rand_on = 1'b0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    b_m_ready = rand_on ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && m_valid && m_ready) begin
      a_cyc.push_back(cyc);
      if (qa.size() == 0) begin
        check("a_unexpected", {48'd0, m_data}, 64'hffff_ffff);
      end else begin
        e = qa.pop_front();
        check("a_data", m_data, e.d);
        check("a_keep", m_keep, e.k);
        check("a_last", m_last, e.l);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && b_m_valid && b_m_ready) begin
      b_outs++;
      if (b_m_last) b_mlast++;
      if (qb.size() == 0) begin
        check("b_unexpected", {48'd0, b_m_data}, 64'hffff_ffff);
      end else begin
        e = qb.pop_front();
        check("b_data", b_m_data, e.d);
        check("b_keep", b_m_keep, e.k);
        check("b_last", b_m_last, e.l);
      end
    end
  end

  task automatic send_a(input logic [31:0] d,
                        input logic [3:0] k,
                        input logic l);
    s_valid = 1'b1;
    s_data  = d;
    s_keep  = k;
    s_last  = l;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_ready) begin
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        return;
      end
    end
    check("a_send_timeout", 0, 1);
    s_valid = 1'b0;
  endtask

  task automatic send_b(input logic [63:0] d,
                        input logic [7:0] k,
                        input logic l);
    b_s_valid = 1'b1;
    b_s_data  = d;
    b_s_keep  = k;
    b_s_last  = l;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (b_s_ready) begin
        @(posedge clk);
        #1;
        b_s_valid = 1'b0;
        return;
      end
    end
    check("b_send_timeout", 0, 1);
    b_s_valid = 1'b0;
  endtask

  task automatic drain_a();
    for (int i = 0; i < 300 && qa.size() != 0; i++) @(posedge clk);
    check("a_drain", qa.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain_b();
    for (int i = 0; i < 20000 && qb.size() != 0; i++) @(posedge clk);
    check("b_drain", qb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [63:0] rd;
    logic [7:0]  rk;
    logic        rl;

    rst = 1'b1;
    s_valid = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0;
    m_ready = 1'b1;
    b_s_valid = 1'b0; b_s_data = '0; b_s_keep = '0; b_s_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mvalid", m_valid, 0);
    check("rst_mlast", m_last, 0);
    check("rst_sready", s_ready, 0);
    check("rst_b_mvalid", b_m_valid, 0);
    rst = 1'b0;
    #1;
    check("sready_after_rst", s_ready, 1);
    @(posedge clk);
    #1;

    // single beat
    qa.push_back('{d: 16'h2211, k: 2'b11, l: 1'b0});
    qa.push_back('{d: 16'h4433, k: 2'b11, l: 1'b1});
    send_a(32'h4433_2211, 4'b1111, 1'b1);
    check("first_mvalid", m_valid, 1);
    check("first_sready_low", s_ready, 0);
    drain_a();

    // back-to-back
    a_cyc.delete();
    qa.push_back('{d: 16'h0201, k: 2'b11, l: 1'b0});
    qa.push_back('{d: 16'h0403, k: 2'b11, l: 1'b0});
    qa.push_back('{d: 16'h1211, k: 2'b11, l: 1'b0});
    qa.push_back('{d: 16'h1413, k: 2'b11, l: 1'b0});
    qa.push_back('{d: 16'h2221, k: 2'b11, l: 1'b0});
    qa.push_back('{d: 16'h2423, k: 2'b11, l: 1'b1});
    send_a(32'h0403_0201, 4'b1111, 1'b0);
    send_a(32'h1413_1211, 4'b1111, 1'b0);
    send_a(32'h2423_2221, 4'b1111, 1'b1);
    drain_a();
    check("b2b_count", a_cyc.size(), 6);
    if (a_cyc.size() >= 6) check("b2b_span", a_cyc[5] - a_cyc[0], 5);

    // backpressure on the second sub-beat
    qa.push_back('{d: 16'h6655, k: 2'b11, l: 1'b0});
    qa.push_back('{d: 16'h8877, k: 2'b11, l: 1'b0});
    send_a(32'h8877_6655, 4'b1111, 1'b0);
    @(negedge clk);
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_mvalid", m_valid, 1);
      check("bp_data", m_data, 16'h8877);
      check("bp_keep", m_keep, 2'b11);
      check("bp_last", m_last, 0);
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    drain_a();

    // keep slicing
    qa.push_back('{d: 16'h3344, k: 2'b00, l: 1'b0});
    qa.push_back('{d: 16'h1122, k: 2'b01, l: 1'b1});
    send_a(32'h1122_3344, 4'b0100, 1'b1);
    drain_a();

    // reset mid-beat
    qa.push_back('{d: 16'hbbaa, k: 2'b11, l: 1'b0});
    qa.push_back('{d: 16'hddcc, k: 2'b11, l: 1'b1});
    send_a(32'hddcc_bbaa, 4'b1111, 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_mvalid", m_valid, 0);
    check("midrst_sready", s_ready, 0);
    check("midrst_popped", qa.size(), 1);
    qa.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("postrst_mvalid", m_valid, 0);
    qa.push_back('{d: 16'h0201, k: 2'b11, l: 1'b0});
    qa.push_back('{d: 16'h0403, k: 2'b11, l: 1'b1});
    send_a(32'h0403_0201, 4'b1111, 1'b1);
    drain_a();

    // random R=8 P=2
    rand_on = 1'b1;
    for (int b = 0; b < 1000; b++) begin
      rd = {$urandom(), $urandom()};
      rk = 8'($urandom());
      rl = ($urandom_range(0, 3) == 0) || (b == 999);
      for (int k = 0; k < NB; k++) begin
        qb.push_back('{d: rd[k*16 +: 16],
                      k: rk[k*2 +: 2],
                      l: rl && (k == NB - 1)});
      end
      if (rl) b_slast++;
      while ($urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
      end
      send_b(rd, rk, rl);
    end
    drain_b();
    rand_on = 1'b0;
    check("rand_outs", b_outs, 1000 * NB);
    check("rand_last_cnt", b_mlast, b_slast);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
